hazard_resolve_ctrl: RTL and testbench
======================================

// Module: hazard_resolve_ctrl
// PURPOSE
//  Consumer side of the hazard detector: turns per-stage hazard flags and register codes into pipeline
//  actions for the 5-stage RV32I core. Outputs are PC/IF-ID hold, ID-EX bubble, IF-ID flush and the
//  registered forwarding selects latched into ID/EX. Sits between the detector and the pipeline registers.
//  Sequences load-use stalls, data-memory wait stalls and branch flushes with a small FSM.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles IF-ID is flushed after a taken branch/jump (1..3)
//  CNT_W         16  width of stall/flush performance counters
// PORTS
//  clk             in   1      core clock, all state updates on rising edge
//  rst_n           in   1      synchronous reset, active low
//  is_hazard1      in   1      IF/ID source matches ID/EX destination
//  hazard_reg1     in   3      operand code for hazard1: 0 none, 1 rs1, 2 rs2, 3 rs1+rs2, 4 rs2 store data
//  is_hazard2      in   1      IF/ID source matches EX/MEM destination
//  hazard_reg2     in   3      operand code for hazard2, same encoding
//  id_ex_is_load   in   1      instruction in ID/EX is a load (LB/LH/LW/LBU/LHU)
//  ex_branch_taken in   1      branch/JAL/JALR resolved taken in EX this cycle
//  mem_busy        in   1      data memory not ready; MEM stage must hold
//  pc_stall        out  1      hold PC
//  if_id_stall     out  1      hold IF/ID register
//  id_ex_bubble    out  1      load NOP into ID/EX
//  if_id_flush     out  1      load NOP into IF/ID
//  fwd_a_sel       out  2      rs1 select into ID/EX: 0 regfile, 1 EX/MEM result, 2 MEM/WB result
//  fwd_b_sel       out  2      rs2 select into ID/EX, same encoding
//  stall_cnt       out  CNT_W  cycles spent in LOAD_STALL or MEM_WAIT, saturating
//  flush_cnt       out  CNT_W  number of flush events entered, saturating
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=RUN, flush counter=0, fwd_*_sel=0, stall_cnt=0, flush_cnt=0;
//   all stall/bubble/flush outputs read 0 in the cycle after reset.
//  States: RUN, LOAD_STALL, MEM_WAIT, FLUSH. Control outputs are combinational from state+inputs;
//   fwd_*_sel are registered (latency 1, captured when ID/EX advances).
//  Operand-hit rule: code c hits rs1 if c==1|3; hits rs2 if c==2|3|4.
//  Priority each cycle: mem_busy > ex_branch_taken > load-use > forwarding.
//  RUN:
//   mem_busy=1 -> all holds asserted (pc_stall, if_id_stall), id_ex_bubble=0, go MEM_WAIT.
//   else ex_branch_taken=1 -> if_id_flush=1, id_ex_bubble=1, load counter FLUSH_CYCLES-1; go FLUSH if >0.
//   else is_hazard1 & id_ex_is_load & code1!=0 -> pc_stall=if_id_stall=id_ex_bubble=1, go LOAD_STALL.
//   else update forwarding: hazard1 hit -> sel=1 (newer wins); else hazard2 hit -> sel=2; else 0.
//  LOAD_STALL: exactly one cycle; holds released, forwarding for the held instruction computed from
//   hazard2 (load now in EX/MEM -> sel=2 on hit), return RUN. mem_busy here -> MEM_WAIT, load still held.
//  MEM_WAIT: pc_stall=if_id_stall=1, fwd_*_sel hold value; exit to RUN on first cycle mem_busy=0.
//   A branch taken during MEM_WAIT is ignored (EX is frozen; re-presented on exit).
//  FLUSH: if_id_flush=1 each cycle, down-counter decrements; return RUN at 0. New taken branch in
//   FLUSH reloads the counter and counts a new flush event. fwd_*_sel forced 0 while flushing.
//  Counters: stall_cnt +1 per cycle in LOAD_STALL or MEM_WAIT; flush_cnt +1 per branch-taken entry;
//   both saturate at all-ones, never wrap.
//  Invalid hazard code 5..7 treated as 0 (no hit). is_hazard=0 overrides any code.
//  Reset mid-stall/flush: returns RUN next cycle, outputs deasserted, no residual bubble.
// TESTING
//  1 Reset: rst_n=0 two cycles with mem_busy=1 -> all outputs 0, state RUN after release.
//  2 Load-use: is_hazard1=1, hazard_reg1=1, id_ex_is_load=1 -> stall+bubble 1 cycle, then fwd_a_sel=2.
//  3 ALU fwd: is_hazard1=1 code 3 and is_hazard2=1 code 2 -> fwd_a_sel=1, fwd_b_sel=1 next cycle, no stall.
//  4 Branch: ex_branch_taken=1 with FLUSH_CYCLES=2 -> if_id_flush high 2 cycles, flush_cnt=1.
//  5 mem_busy held 5 cycles during load-use -> pc_stall high 6 cycles total, stall_cnt=6.
//  6 Saturation: CNT_W=4, 20 stall cycles -> stall_cnt=15; rst_n=0 mid-FLUSH -> flush drops next cycle.

Source files
------------

// File: rtl/hazard_resolve_ctrl.sv
// Pipeline hazard resolution: converts detector flags into PC/IF-ID holds, ID-EX bubbles,
// IF-ID flushes and registered forwarding selects, sequenced by a four-state FSM.
module hazard_resolve_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             is_hazard1,
    input  logic [2:0]       hazard_reg1,
    input  logic             is_hazard2,
    input  logic [2:0]       hazard_reg2,
    input  logic             id_ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {ST_RUN, ST_LOAD_STALL, ST_MEM_WAIT, ST_FLUSH} state_t;

    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [1:0]       fcnt_reg, fcnt_next;
    logic [1:0]       fwd_a_reg, fwd_a_next;
    logic [1:0]       fwd_b_reg, fwd_b_next;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
    logic             flush_evt;

    // Index 0 is the ID/EX (newer) hazard, index 1 the EX/MEM (older) hazard.
    logic [1:0][2:0] codes;
    logic [1:0]      valid;
    logic [1:0]      hit_rs1, hit_rs2;

    assign codes = {hazard_reg2, hazard_reg1};
    assign valid = {is_hazard2, is_hazard1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hit
            assign hit_rs1[gi] = valid[gi] & ((codes[gi] == 3'd1) | (codes[gi] == 3'd3));
            assign hit_rs2[gi] = valid[gi] & ((codes[gi] == 3'd2) | (codes[gi] == 3'd3) |
                                              (codes[gi] == 3'd4));
        end
    endgenerate

    logic load_use;
    assign load_use = id_ex_is_load & (hit_rs1[0] | hit_rs2[0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_RUN;
            fcnt_reg      <= 2'd0;
            fwd_a_reg     <= 2'd0;
            fwd_b_reg     <= 2'd0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            fcnt_reg  <= fcnt_next;
            fwd_a_reg <= fwd_a_next;
            fwd_b_reg <= fwd_b_next;
            if ((state_reg == ST_LOAD_STALL || state_reg == ST_MEM_WAIT) && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (flush_evt && flush_cnt_reg != '1)
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        fcnt_next  = fcnt_reg;
        fwd_a_next = fwd_a_reg;
        fwd_b_next = fwd_b_reg;
        flush_evt  = 1'b0;
        case (state_reg)
            ST_RUN, ST_LOAD_STALL: begin
                if (mem_busy) begin
                    state_next = ST_MEM_WAIT;
                end else if (ex_branch_taken) begin
                    flush_evt  = 1'b1;
                    fcnt_next  = FLUSH_RELOAD;
                    state_next = (FLUSH_RELOAD != 2'd0) ? ST_FLUSH : ST_RUN;
                    fwd_a_next = 2'd0;
                    fwd_b_next = 2'd0;
                end else if (state_reg == ST_LOAD_STALL) begin
                    // The load has moved to EX/MEM, so only the older hazard can forward.
                    state_next = ST_RUN;
                    fwd_a_next = hit_rs1[1] ? 2'd2 : 2'd0;
                    fwd_b_next = hit_rs2[1] ? 2'd2 : 2'd0;
                end else if (load_use) begin
                    state_next = ST_LOAD_STALL;
                    fwd_a_next = 2'd0;
                    fwd_b_next = 2'd0;
                end else begin
                    fwd_a_next = hit_rs1[0] ? 2'd1 : (hit_rs1[1] ? 2'd2 : 2'd0);
                    fwd_b_next = hit_rs2[0] ? 2'd1 : (hit_rs2[1] ? 2'd2 : 2'd0);
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_busy)
                    state_next = ST_RUN;
            end
            ST_FLUSH: begin
                fwd_a_next = 2'd0;
                fwd_b_next = 2'd0;
                if (mem_busy) begin
                    state_next = ST_FLUSH;
                end else if (ex_branch_taken) begin
                    flush_evt  = 1'b1;
                    fcnt_next  = FLUSH_RELOAD;
                    state_next = (FLUSH_RELOAD != 2'd0) ? ST_FLUSH : ST_RUN;
                end else begin
                    fcnt_next  = (fcnt_reg != 2'd0) ? fcnt_reg - 2'd1 : 2'd0;
                    state_next = (fcnt_reg <= 2'd1) ? ST_RUN : ST_FLUSH;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Outputs are forced low while reset is asserted so no stale bubble leaks out.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        if (rst_n) begin
            case (state_reg)
                ST_RUN: begin
                    if (mem_busy) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                    end else if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                end
                ST_LOAD_STALL: begin
                    if (mem_busy) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                    end else if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    pc_stall    = mem_busy;
                    if_id_stall = mem_busy;
                end
                ST_FLUSH: begin
                    if_id_flush = 1'b1;
                    if (mem_busy) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                    end else if (ex_branch_taken) begin
                        id_ex_bubble = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fwd_a_sel = fwd_a_reg;
    assign fwd_b_sel = fwd_b_reg;
    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_resolve_ctrl.sv
// Directed bench for hazard_resolve_ctrl: reset, load-use, forwarding, flush,
// memory-wait and counter saturation with hand-computed expectations.
module tb_hazard_resolve_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             is_hazard1, is_hazard2, id_ex_is_load, ex_branch_taken, mem_busy;
    logic [2:0]       hazard_reg1, hazard_reg2;
    logic             pc_stall, if_id_stall, id_ex_bubble, if_id_flush;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;
    int stall_seen;

    hazard_resolve_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .is_hazard1(is_hazard1), .hazard_reg1(hazard_reg1),
        .is_hazard2(is_hazard2), .hazard_reg2(hazard_reg2),
        .id_ex_is_load(id_ex_is_load), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic h1, input logic [2:0] r1, input logic h2, input logic [2:0] r2,
                         input logic ld, input logic br, input logic mb);
        is_hazard1 = h1; hazard_reg1 = r1;
        is_hazard2 = h2; hazard_reg2 = r2;
        id_ex_is_load = ld; ex_branch_taken = br; mem_busy = mb;
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        // Reset held two cycles with mem_busy asserted
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1);
        check("rst_pc_stall", pc_stall, 0);
        check("rst_if_id_stall", if_id_stall, 0);
        cyc(); cyc();
        check("rst_fwd_a", fwd_a_sel, 0);
        check("rst_fwd_b", fwd_b_sel, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        check("post_rst_bubble", id_ex_bubble, 0);
        check("post_rst_flush", if_id_flush, 0);
        $display("txn reset: pc_stall=%0d flush=%0d", pc_stall, if_id_flush);

        // Load-use on rs1
        drive(1, 1, 0, 0, 1, 0, 0);
        check("lu_pc_stall", pc_stall, 1);
        check("lu_if_id_stall", if_id_stall, 1);
        check("lu_bubble", id_ex_bubble, 1);
        cyc();
        drive(0, 0, 1, 1, 0, 0, 0);
        check("lu_release_stall", pc_stall, 0);
        check("lu_release_bubble", id_ex_bubble, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("lu_fwd_a", fwd_a_sel, 2);
        check("lu_fwd_b", fwd_b_sel, 0);
        check("lu_stall_cnt", stall_cnt, 1);
        $display("txn load_use: fwd_a=%0d stall_cnt=%0d", fwd_a_sel, stall_cnt);

        // ALU forwarding: newer hazard wins on both operands
        drive(1, 3, 1, 2, 0, 0, 0);
        check("alu_no_stall", pc_stall, 0);
        cyc();
        check("alu_fwd_a", fwd_a_sel, 1);
        check("alu_fwd_b", fwd_b_sel, 1);
        $display("txn alu_fwd: fwd_a=%0d fwd_b=%0d", fwd_a_sel, fwd_b_sel);
        // Invalid code with a load ahead: no stall, no forwarding
        drive(1, 5, 0, 0, 1, 0, 0);
        check("inv_no_stall", pc_stall, 0);
        cyc();
        check("inv_fwd_a", fwd_a_sel, 0);
        check("inv_fwd_b", fwd_b_sel, 0);
        // is_hazard low masks the code
        drive(0, 1, 0, 3, 1, 0, 0);
        check("mask_no_stall", pc_stall, 0);
        cyc();
        check("mask_fwd_a", fwd_a_sel, 0);
        // Older hazard only, store data on rs2
        drive(0, 0, 1, 4, 0, 0, 0);
        cyc();
        check("st_fwd_a", fwd_a_sel, 0);
        check("st_fwd_b", fwd_b_sel, 2);
        $display("txn store_fwd: fwd_a=%0d fwd_b=%0d", fwd_a_sel, fwd_b_sel);

        // Taken branch: two flush cycles
        drive(0, 0, 1, 4, 0, 1, 0);
        check("br_flush0", if_id_flush, 1);
        check("br_bubble0", id_ex_bubble, 1);
        cyc();
        drive(0, 0, 1, 4, 0, 0, 0);
        check("br_flush1", if_id_flush, 1);
        check("br_bubble1", id_ex_bubble, 0);
        check("br_fwd_b_forced", fwd_b_sel, 0);
        check("br_flush_cnt", flush_cnt, 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("br_flush_done", if_id_flush, 0);
        $display("txn branch: flush_cnt=%0d", flush_cnt);

        // Branch re-taken inside FLUSH reloads the counter
        drive(0, 0, 0, 0, 0, 1, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 1, 0);
        check("rebr_flush", if_id_flush, 1);
        check("rebr_bubble", id_ex_bubble, 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rebr_flush_ext", if_id_flush, 1);
        check("rebr_flush_cnt", flush_cnt, 3);
        cyc();
        check("rebr_flush_done", if_id_flush, 0);
        $display("txn rebranch: flush_cnt=%0d", flush_cnt);

        // mem_busy for 5 cycles right after a load-use stall
        do_reset();
        stall_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      drive(1, 2, 0, 0, 1, 0, 0);
            else if (i <= 5) drive(0, 0, 1, 2, 0, (i == 3), 1);
            else             drive(0, 0, 0, 0, 0, 0, 0);
            if (pc_stall) stall_seen++;
            if (i == 3) begin
                check("mw_if_id_stall", if_id_stall, 1);
                check("mw_branch_ignored", if_id_flush, 0);
                check("mw_no_bubble", id_ex_bubble, 0);
            end
            cyc();
        end
        check("mw_pc_stall_cycles", stall_seen, 6);
        check("mw_stall_cnt", stall_cnt, 6);
        check("mw_flush_cnt", flush_cnt, 0);
        $display("txn mem_wait: pc_stall_cycles=%0d stall_cnt=%0d", stall_seen, stall_cnt);

        // Saturation of a 4-bit stall counter
        do_reset();
        for (int i = 0; i < 22; i++) begin
            if (i == 0)       drive(1, 1, 0, 0, 1, 0, 0);
            else if (i <= 20) drive(0, 0, 0, 0, 0, 0, 1);
            else              drive(0, 0, 0, 0, 0, 0, 0);
            cyc();
        end
        check("sat_stall_cnt", stall_cnt, 15);
        $display("txn saturate: stall_cnt=%0d", stall_cnt);

        // Reset in the middle of a flush
        drive(0, 0, 0, 0, 0, 1, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("mid_flush_active", if_id_flush, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_flush", if_id_flush, 0);
        cyc();
        rst_n = 1'b1;
        #1;
        check("after_rst_flush", if_id_flush, 0);
        check("after_rst_bubble", id_ex_bubble, 0);
        check("after_rst_flush_cnt", flush_cnt, 0);
        check("after_rst_stall_cnt", stall_cnt, 0);
        cyc();
        check("after_rst_flush_next", if_id_flush, 0);
        $display("txn reset_mid_flush: flush=%0d", if_id_flush);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
